// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the pipeline-side request ports and the SRAM-like bus ports of
// mem_bus_arbiter. The master modport is the arbiter's view, and the slave
// modport is the view of its environment (the pipeline plus the bus slave).
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Instruction-fetch requester
  logic                  inst_req;
  logic [ADDR_W-1:0]     inst_addr;
  logic [DATA_W-1:0]     inst_rdata;
  logic                  inst_valid;
  logic                  inst_stall;

  // Load/store requester
  logic                  data_req;
  logic                  data_wr;
  logic [DATA_W/8-1:0]   data_wstrb;
  logic [ADDR_W-1:0]     data_addr;
  logic [DATA_W-1:0]     data_wdata;
  logic [DATA_W-1:0]     data_rdata;
  logic                  data_valid;
  logic                  data_stall;

  logic                  flush;

  // Shared CPU bus
  logic                  bus_req;
  logic                  bus_wr;
  logic [DATA_W/8-1:0]   bus_wstrb;
  logic [ADDR_W-1:0]     bus_addr;
  logic [DATA_W-1:0]     bus_wdata;
  logic                  bus_addr_ok;
  logic                  bus_data_ok;
  logic [DATA_W-1:0]     bus_rdata;

  modport master (
    input  inst_req, inst_addr,
    output inst_rdata, inst_valid, inst_stall,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_rdata, data_valid, data_stall,
    input  flush,
    output bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport slave (
    output inst_req, inst_addr,
    input  inst_rdata, inst_valid, inst_stall,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_rdata, data_valid, data_stall,
    output flush,
    input  bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one SRAM-like bus between instruction fetch and the
// load/store port, with one outstanding transaction at a time
// (IDLE -> ADDR -> RESP). By default, data requests have fixed priority.
// Define ARB_RR_EN to alternate grants when both requesters contend.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,     // asynchronous, active-low
  mem_bus_arbiter_if.master bus_if
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_RESP} state_t;
  typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_t;

  state_t              r_state;
  owner_t              r_owner;
  logic                r_cancel;
  logic                r_bus_req;
  logic                r_wr;
  logic [STRB_W-1:0]   r_wstrb;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  logic                w_any_req;
  logic                w_grant_data;
  logic                w_resp_ok;
  logic                w_inst_valid;
  logic                w_data_valid;

`ifdef ARB_RR_EN
  owner_t r_last_grant;

  // On contention, grant the requester that was not served last; a lone requester always wins
  always_comb begin
    w_grant_data = bus_if.data_req & (~bus_if.inst_req | (r_last_grant == OWN_INST));
  end

  // Remember who won the most recent grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= OWN_INST;
    end else if (r_state == ST_IDLE && w_any_req) begin
      r_last_grant <= w_grant_data ? OWN_DATA : OWN_INST;
    end
  end
`else
  // Fixed priority: a data access always beats a fetch
  always_comb begin
    w_grant_data = bus_if.data_req;
  end
`endif

  // Request presence and qualified completion of the owned transaction
  always_comb begin
    w_any_req    = bus_if.data_req | bus_if.inst_req;
    w_resp_ok    = (r_state == ST_RESP) & bus_if.bus_data_ok;
    // A flush in the same cycle as the response also suppresses it
    w_inst_valid = w_resp_ok & (r_owner == OWN_INST) & ~r_cancel & ~bus_if.flush;
    w_data_valid = w_resp_ok & (r_owner == OWN_DATA);
  end

  // Transaction sequencer; latches the winner's fields on grant and holds them until IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_owner   <= OWN_INST;
      r_cancel  <= 1'b0;
      r_bus_req <= 1'b0;
      r_wr      <= 1'b0;
      r_wstrb   <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cancel <= 1'b0;
          if (w_any_req) begin
            r_state   <= ST_ADDR;
            r_bus_req <= 1'b1;
            if (w_grant_data) begin
              r_owner <= OWN_DATA;
              r_wr    <= bus_if.data_wr;
              r_wstrb <= bus_if.data_wr ? bus_if.data_wstrb : '0;
              r_addr  <= bus_if.data_addr;
              r_wdata <= bus_if.data_wdata;
            end else begin
              r_owner <= OWN_INST;
              r_wr    <= 1'b0;
              r_wstrb <= '0;
              r_addr  <= bus_if.inst_addr;
              r_wdata <= '0;
            end
          end
        end
        ST_ADDR: begin
          if (bus_if.flush && r_owner == OWN_INST) begin
            r_cancel <= 1'b1;
          end
          if (bus_if.bus_addr_ok) begin
            r_state   <= ST_RESP;
            r_bus_req <= 1'b0;
          end
        end
        ST_RESP: begin
          if (bus_if.flush && r_owner == OWN_INST) begin
            r_cancel <= 1'b1;
          end
          // Returning to IDLE wins over a flush in the same cycle, so cancel never leaks
          if (bus_if.bus_data_ok) begin
            r_state  <= ST_IDLE;
            r_cancel <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_bus_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus_if.bus_req    = r_bus_req;
  assign bus_if.bus_wr     = r_wr;
  assign bus_if.bus_wstrb  = r_wstrb;
  assign bus_if.bus_addr   = r_addr;
  assign bus_if.bus_wdata  = r_wdata;

  assign bus_if.inst_valid = w_inst_valid;
  assign bus_if.inst_rdata = w_inst_valid ? bus_if.bus_rdata : '0;
  assign bus_if.data_valid = w_data_valid;
  assign bus_if.data_rdata = w_data_valid ? bus_if.bus_rdata : '0;

  assign bus_if.inst_stall = bus_if.inst_req & ~w_inst_valid;
  assign bus_if.data_stall = bus_if.data_req & ~w_data_valid;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter with hand-computed expected values.
// When ARB_RR_EN is defined, the contention sequence expects alternating grants.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif ();

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plays the bus slave for one transaction. On entry, the requests are visible in an IDLE cycle.
  // On return, the first IDLE cycle after completion has just begun.
  task automatic xact(input string tag, input bit is_inst, input logic [31:0] exp_addr,
                      input bit exp_wr, input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                      input logic [31:0] rdata, input int unsigned a_dly, input int unsigned d_dly);
    bit done;
    @(negedge clk);
    check({tag, ".idle_req"}, bif.bus_req, 1'b0);
    tick();
    for (int unsigned k = 0; k <= a_dly; k++) begin
      bif.bus_addr_ok = (k == a_dly);
      @(negedge clk);
      check({tag, ".bus_req"}, bif.bus_req, 1'b1);
      check({tag, ".bus_addr"}, bif.bus_addr, exp_addr);
      check({tag, ".bus_wr"}, bif.bus_wr, exp_wr);
      check({tag, ".bus_wstrb"}, bif.bus_wstrb, exp_wstrb);
      if (exp_wr) check({tag, ".bus_wdata"}, bif.bus_wdata, exp_wdata);
      if (is_inst) check({tag, ".istall_a"}, bif.inst_stall, 1'b1);
      else         check({tag, ".dstall_a"}, bif.data_stall, 1'b1);
      tick();
    end
    bif.bus_addr_ok = 1'b0;
    for (int unsigned k = 0; k <= d_dly; k++) begin
      done = (k == d_dly);
      bif.bus_data_ok = done;
      bif.bus_rdata   = rdata;
      @(negedge clk);
      check({tag, ".resp_req"}, bif.bus_req, 1'b0);
      if (is_inst) begin
        check({tag, ".ivalid"}, bif.inst_valid, done);
        check({tag, ".irdata"}, bif.inst_rdata, done ? rdata : 32'h0);
        check({tag, ".istall"}, bif.inst_stall, !done);
        check({tag, ".dvalid0"}, bif.data_valid, 1'b0);
      end else begin
        check({tag, ".dvalid"}, bif.data_valid, done);
        check({tag, ".drdata"}, bif.data_rdata, done ? rdata : 32'h0);
        check({tag, ".dstall"}, bif.data_stall, !done);
        check({tag, ".ivalid0"}, bif.inst_valid, 1'b0);
      end
      tick();
    end
    bif.bus_data_ok = 1'b0;
    bif.bus_rdata   = 32'h0;
  endtask

  logic [31:0] rr_addr [3];
  bit          rr_inst [3];

  initial begin
    bif.inst_req = 0; bif.inst_addr = '0;
    bif.data_req = 0; bif.data_wr = 0; bif.data_wstrb = '0;
    bif.data_addr = '0; bif.data_wdata = '0; bif.flush = 0;
    bif.bus_addr_ok = 0; bif.bus_data_ok = 0; bif.bus_rdata = '0;

    // Reset state
    @(negedge clk);
    check("rst.bus_req", bif.bus_req, 1'b0);
    check("rst.bus_addr", bif.bus_addr, 32'h0);
    check("rst.bus_wr", bif.bus_wr, 1'b0);
    check("rst.bus_wstrb", bif.bus_wstrb, 4'h0);
    check("rst.ivalid", bif.inst_valid, 1'b0);
    check("rst.dvalid", bif.data_valid, 1'b0);
    check("rst.irdata", bif.inst_rdata, 32'h0);
    tick();
    rst = 1'b1;
    // A stale response in IDLE is ignored
    bif.bus_data_ok = 1'b1; bif.bus_rdata = 32'hFFFF0000;
    @(negedge clk);
    check("stale.ivalid", bif.inst_valid, 1'b0);
    check("stale.dvalid", bif.data_valid, 1'b0);
    check("stale.drdata", bif.data_rdata, 32'h0);
    tick();
    bif.bus_data_ok = 1'b0; bif.bus_rdata = '0;

    // Fetch only, zero-wait slave: valid two cycles after the request
    bif.inst_req = 1; bif.inst_addr = 32'hBFC00000;
    xact("fetch", 1, 32'hBFC00000, 0, 4'h0, 32'h0, 32'h3C08BFC0, 0, 0);
    bif.inst_req = 0;
    @(negedge clk);
    check("fetch.ivalid_after", bif.inst_valid, 1'b0);
    check("fetch.istall_after", bif.inst_stall, 1'b0);
    tick();

    // A store with a fetch held throughout; the fetch is served afterwards
    bif.data_req = 1; bif.data_wr = 1; bif.data_wstrb = 4'b0100;
    bif.data_addr = 32'h80001004; bif.data_wdata = 32'h5A5A5A5A;
    bif.inst_req = 1; bif.inst_addr = 32'hBFC00004;
    xact("store", 0, 32'h80001004, 1, 4'b0100, 32'h5A5A5A5A, 32'h11112222, 0, 0);
    bif.data_req = 0; bif.data_wr = 0; bif.data_wstrb = '0;
    xact("store_fetch", 1, 32'hBFC00004, 0, 4'h0, 32'h0, 32'h24020001, 0, 0);
    bif.inst_req = 0;
    tick();

    // Both requests raised in the same cycle: the data access wins, then the fetch
    bif.data_req = 1; bif.data_wr = 0; bif.data_wstrb = 4'hF; bif.data_addr = 32'h80002000;
    bif.inst_req = 1; bif.inst_addr = 32'hBFC00008;
    xact("cont_d", 0, 32'h80002000, 0, 4'h0, 32'h0, 32'hCAFEF00D, 0, 0);
    bif.data_req = 0;
    xact("cont_i", 1, 32'hBFC00008, 0, 4'h0, 32'h0, 32'h00000000, 0, 0);
    bif.inst_req = 0;
    tick();

    // Both requests held across three transactions
`ifdef ARB_RR_EN
    rr_addr = '{32'h80004000, 32'hBFC00020, 32'h80004000};
    rr_inst = '{0, 1, 0};
`else
    rr_addr = '{32'h80004000, 32'h80004000, 32'h80004000};
    rr_inst = '{0, 0, 0};
`endif
    bif.data_req = 1; bif.data_wr = 0; bif.data_addr = 32'h80004000;
    bif.inst_req = 1; bif.inst_addr = 32'hBFC00020;
    for (int i = 0; i < 3; i++) begin
      xact($sformatf("grant%0d", i), rr_inst[i], rr_addr[i], 0, 4'h0, 32'h0,
           32'h10000000 + 32'(i), 0, 0);
    end
    bif.data_req = 0; bif.inst_req = 0;
    tick();

    // Slow slave: addr_ok after 3 waits, data_ok after 4 more
    bif.data_req = 1; bif.data_wr = 0; bif.data_addr = 32'h80003000;
    xact("slow", 0, 32'h80003000, 0, 4'h0, 32'h0, 32'h87654321, 3, 4);
    bif.data_req = 0;
    tick();

    // A flush while the fetch waits in RESP: the response is consumed silently
    bif.inst_req = 1; bif.inst_addr = 32'hBFC00010;
    tick();                                   // ADDR
    bif.bus_addr_ok = 1;
    tick();                                   // RESP
    bif.bus_addr_ok = 0; bif.flush = 1;
    @(negedge clk);
    check("flush.istall_f", bif.inst_stall, 1'b1);
    tick();
    bif.flush = 0; bif.bus_data_ok = 1; bif.bus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("flush.ivalid", bif.inst_valid, 1'b0);
    check("flush.irdata", bif.inst_rdata, 32'h0);
    check("flush.istall", bif.inst_stall, 1'b1);
    tick();
    bif.bus_data_ok = 0; bif.bus_rdata = '0; bif.inst_addr = 32'hBFC00380;
    xact("post_flush", 1, 32'hBFC00380, 0, 4'h0, 32'h0, 32'h40806000, 0, 0);

    // Flush arriving together with data_ok suppresses the response
    bif.inst_addr = 32'hBFC00384;
    tick();                                   // ADDR
    bif.bus_addr_ok = 1;
    tick();                                   // RESP
    bif.bus_addr_ok = 0; bif.bus_data_ok = 1; bif.flush = 1; bif.bus_rdata = 32'h12345678;
    @(negedge clk);
    check("flush_same.ivalid", bif.inst_valid, 1'b0);
    check("flush_same.irdata", bif.inst_rdata, 32'h0);
    tick();
    bif.bus_data_ok = 0; bif.flush = 0; bif.bus_rdata = '0; bif.inst_addr = 32'hBFC00388;
    xact("post_flush2", 1, 32'hBFC00388, 0, 4'h0, 32'h0, 32'h0000000C, 0, 0);
    bif.inst_req = 0;
    tick();

    // Reset asserted during ADDR drops bus_req at once; a later stray data_ok is ignored
    bif.inst_req = 1; bif.inst_addr = 32'hBFC00400;
    tick();                                   // ADDR
    @(negedge clk);
    check("rstmid.bus_req_pre", bif.bus_req, 1'b1);
    #1 rst = 1'b0;
    #1;
    check("rstmid.bus_req", bif.bus_req, 1'b0);
    check("rstmid.bus_addr", bif.bus_addr, 32'h0);
    bif.inst_req = 0;
    tick();
    rst = 1'b1;
    bif.bus_data_ok = 1; bif.bus_rdata = 32'hBAADF00D;
    @(negedge clk);
    check("rstmid.ivalid", bif.inst_valid, 1'b0);
    check("rstmid.dvalid", bif.data_valid, 1'b0);
    check("rstmid.irdata", bif.inst_rdata, 32'h0);
    tick();
    bif.bus_data_ok = 0;
    @(negedge clk);
    check("rstmid.idle", bif.bus_req, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
